// File: rtl/poly_arith_pkg.sv
// Shared polynomial-arithmetic types.
//   coeff_t          : one coefficient / twiddle word
//   pe_mode_e        : operation selector for a butterfly processing element
//   pe_issue_state_e : state encoding of the PE0 issue controller
package poly_arith_pkg;

    localparam int unsigned COEFF_W = 12;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        PE_MODE_NTT  = 2'd0,
        PE_MODE_INTT = 2'd1,
        PE_MODE_MUL  = 2'd2,
        PE_MODE_ADD  = 2'd3
    } pe_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } pe_issue_state_e;

endpackage

// File: rtl/pe_inflight_cnt.sv
// Saturating up/down counter of operand sets issued to PE0 but not yet
// returned.
//   clk, rst     : clock, synchronous active-high reset
//   inc_i        : one request accepted this cycle
//   dec_i        : one result returned this cycle
//   count_o      : current count
//   underflow_o  : a return arrived while the count was already zero
module pe_inflight_cnt #(
    parameter int unsigned MAX_COUNT = 8,
    parameter int unsigned W         = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         underflow_o
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX_COUNT);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != MAX_CNT)) begin
            count_d = count_q + ONE;
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A return with nothing outstanding cannot belong to any issued request,
    // even if a new request is accepted in the same cycle.
    assign underflow_o = dec_i && (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/pe0_issuer.sv
// Issue controller for butterfly PE0: accepts operand sets over a
// valid/ready handshake, registers them towards PE0, tracks results still in
// flight and only lets the PE mode change once the pipeline is empty.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid_i/req_ready_o  : upstream handshake
//   req_a_i/b_i/w_i, req_mode_i : operand payload and requested mode
//   a0_o/b0_o/w0_o, ctrl_o, valid_o : registered PE0 inputs
//   pe_valid_i               : PE0 result return
//   flush_i / drain_done_o   : drain request / one-cycle completion pulse
//   inflight_o, busy_o       : in-flight count, controller not idle
//   err_ghost_o              : sticky, a result came back with none pending
module pe0_issuer
    import poly_arith_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  coeff_t           req_a_i,
    input  coeff_t           req_b_i,
    input  coeff_t           req_w_i,
    input  pe_mode_e         req_mode_i,
    output coeff_t           a0_o,
    output coeff_t           b0_o,
    output coeff_t           w0_o,
    output pe_mode_e         ctrl_o,
    output logic             valid_o,
    input  logic             pe_valid_i,
    input  logic             flush_i,
    output logic             drain_done_o,
    output logic [CNT_W-1:0] inflight_o,
    output logic             busy_o,
    output logic             err_ghost_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    pe_issue_state_e  state_q, state_d;
    coeff_t           a_q, b_q, w_q;
    pe_mode_e         ctrl_q;
    logic             valid_q;
    logic             drain_done_q, drain_done_d;
    logic             ghost_q;
    logic [CNT_W-1:0] cnt;
    logic             underflow;
    logic             mode_clash;
    logic             accept;
    logic             last_return;

    pe_inflight_cnt #(
        .MAX_COUNT (MAX_INFLIGHT),
        .W         (CNT_W)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (accept),
        .dec_i       (pe_valid_i),
        .count_o     (cnt),
        .underflow_o (underflow)
    );

    // Ready depends on registered state and the requested mode only, never on
    // req_valid_i.
    assign mode_clash  = (cnt != '0) && (req_mode_i != ctrl_q);
    assign req_ready_o = (state_q != DRAIN) && (cnt < MAX_CNT) && !mode_clash;
    // A flush in the same cycle always wins over a request.
    assign accept      = req_valid_i && req_ready_o && !flush_i;
    // Counter is zero after this edge (already empty, or last result returning).
    assign last_return = (cnt == '0) || ((cnt == ONE) && pe_valid_i);

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i)     state_d = DRAIN;
                else if (accept) state_d = STREAM;
            end
            STREAM: begin
                if (flush_i)                        state_d = DRAIN;
                else if (req_valid_i && mode_clash) state_d = DRAIN;
                else if (!accept && last_return)    state_d = IDLE;
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            w_q          <= '0;
            ctrl_q       <= PE_MODE_NTT;
            drain_done_q <= 1'b0;
            ghost_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= accept;
            drain_done_q <= drain_done_d;
            if (accept) begin
                a_q    <= req_a_i;
                b_q    <= req_b_i;
                w_q    <= req_w_i;
                ctrl_q <= req_mode_i;
            end
            if (underflow) ghost_q <= 1'b1;
        end
    end

    assign a0_o         = a_q;
    assign b0_o         = b_q;
    assign w0_o         = w_q;
    assign ctrl_o       = ctrl_q;
    assign valid_o      = valid_q;
    assign drain_done_o = drain_done_q;
    assign inflight_o   = cnt;
    assign busy_o       = (state_q != IDLE);
    assign err_ghost_o  = ghost_q;

endmodule

// File: tb/tb_pe0_issuer.sv
module tb_pe0_issuer;
    import poly_arith_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid_i;
    logic       req_ready_o;
    coeff_t     req_a_i, req_b_i, req_w_i;
    pe_mode_e   req_mode_i;
    coeff_t     a0_o, b0_o, w0_o;
    pe_mode_e   ctrl_o;
    logic       valid_o;
    logic       pe_valid_i;
    logic       flush_i;
    logic       drain_done_o;
    logic [3:0] inflight_o;
    logic       busy_o;
    logic       err_ghost_o;

    always #5 clk = ~clk;

    pe0_issuer #(
        .MAX_INFLIGHT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_w_i      (req_w_i),
        .req_mode_i   (req_mode_i),
        .a0_o         (a0_o),
        .b0_o         (b0_o),
        .w0_o         (w0_o),
        .ctrl_o       (ctrl_o),
        .valid_o      (valid_o),
        .pe_valid_i   (pe_valid_i),
        .flush_i      (flush_i),
        .drain_done_o (drain_done_o),
        .inflight_o   (inflight_o),
        .busy_o       (busy_o),
        .err_ghost_o  (err_ghost_o)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_w_i     = '0;
        req_mode_i  = PE_MODE_NTT;
        pe_valid_i  = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned sent, pend, m, budget;
        pe_mode_e    mctrl;
        logic        acc;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_valid", valid_o, 0);
        chk("rst_a0", a0_o, 0);
        chk("rst_b0", b0_o, 0);
        chk("rst_w0", w0_o, 0);
        chk("rst_ctrl", ctrl_o, PE_MODE_NTT);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ghost", err_ghost_o, 0);
        chk("rst_drain_done", drain_done_o, 0);
        chk("rst_ready", req_ready_o, 1);

        // ---------------- 4 NTT back-to-back ----------------
        req_valid_i = 1'b1;
        req_mode_i  = PE_MODE_NTT;
        for (int i = 0; i < 4; i++) begin
            req_a_i = coeff_t'(i + 1);
            req_b_i = coeff_t'(i + 16);
            req_w_i = coeff_t'(i + 32);
            tick();
            chk("b2b_valid", valid_o, 1);
            chk("b2b_a0", a0_o, i + 1);
            chk("b2b_b0", b0_o, i + 16);
            chk("b2b_w0", w0_o, i + 32);
            chk("b2b_inflight", inflight_o, i + 1);
        end
        req_valid_i = 1'b0;
        tick();
        chk("b2b_valid_off", valid_o, 0);
        chk("b2b_hold_a0", a0_o, 4);
        chk("b2b_inflight4", inflight_o, 4);
        chk("b2b_busy", busy_o, 1);

        // ---------------- mode switch with 3 NTT in flight ----------------
        pe_valid_i = 1'b1;
        tick();
        pe_valid_i = 1'b0;
        chk("sw_inflight3", inflight_o, 3);
        req_valid_i = 1'b1;
        req_mode_i  = PE_MODE_INTT;
        req_a_i     = 12'h123;
        req_b_i     = 12'h456;
        req_w_i     = 12'h789;
        #1;
        chk("sw_ready_blocked", req_ready_o, 0);
        tick();
        chk("sw_ctrl_ntt", ctrl_o, PE_MODE_NTT);
        chk("sw_no_valid", valid_o, 0);
        chk("sw_busy", busy_o, 1);
        pe_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_drain_ctrl", ctrl_o, PE_MODE_NTT);
            chk("sw_drain_ready", req_ready_o, 0);
            chk("sw_drain_cnt", inflight_o, 2 - i);
        end
        pe_valid_i = 1'b0;
        tick();
        chk("sw_done_pulse", drain_done_o, 1);
        chk("sw_idle", busy_o, 0);
        chk("sw_ready_now", req_ready_o, 1);
        tick();
        chk("sw_valid", valid_o, 1);
        chk("sw_ctrl_intt", ctrl_o, PE_MODE_INTT);
        chk("sw_a0", a0_o, 12'h123);
        chk("sw_inflight1", inflight_o, 1);
        chk("sw_done_low", drain_done_o, 0);
        req_valid_i = 1'b0;
        pe_valid_i  = 1'b1;
        tick();
        pe_valid_i = 1'b0;
        chk("sw_empty", inflight_o, 0);
        chk("sw_back_idle", busy_o, 0);
        chk("sw_no_ghost", err_ghost_o, 0);

        // ---------------- full at MAX_INFLIGHT ----------------
        do_reset();
        req_valid_i = 1'b1;
        req_mode_i  = PE_MODE_NTT;
        for (int i = 0; i < 8; i++) tick();
        chk("full_cnt8", inflight_o, 8);
        chk("full_ready0", req_ready_o, 0);
        tick();
        chk("full_no_accept", valid_o, 0);
        chk("full_hold8", inflight_o, 8);
        req_valid_i = 1'b0;
        pe_valid_i  = 1'b1;
        tick();
        pe_valid_i = 1'b0;
        chk("full_cnt7", inflight_o, 7);
        chk("full_ready1", req_ready_o, 1);

        // ---------------- flush with 2 in flight ----------------
        do_reset();
        req_valid_i = 1'b1;
        tick();
        tick();
        req_valid_i = 1'b0;
        flush_i     = 1'b1;
        tick();
        chk("fl_busy", busy_o, 1);
        chk("fl_ready0", req_ready_o, 0);
        chk("fl_cnt2", inflight_o, 2);
        pe_valid_i = 1'b1;   // flush still high: ignored in DRAIN
        tick();
        flush_i = 1'b0;
        chk("fl_no_done1", drain_done_o, 0);
        tick();
        pe_valid_i = 1'b0;
        chk("fl_cnt0", inflight_o, 0);
        chk("fl_no_done2", drain_done_o, 0);
        tick();
        chk("fl_done", drain_done_o, 1);
        chk("fl_idle", busy_o, 0);
        tick();
        chk("fl_done_once", drain_done_o, 0);

        // ---------------- flush beats request in IDLE ----------------
        do_reset();
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        tick();
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk("fw_no_valid", valid_o, 0);
        chk("fw_cnt0", inflight_o, 0);
        chk("fw_busy", busy_o, 1);
        tick();
        chk("fw_done", drain_done_o, 1);
        chk("fw_idle", busy_o, 0);

        // ---------------- ghost result ----------------
        do_reset();
        pe_valid_i = 1'b1;
        tick();
        pe_valid_i = 1'b0;
        chk("gh_set", err_ghost_o, 1);
        chk("gh_cnt0", inflight_o, 0);
        tick();
        chk("gh_sticky", err_ghost_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("gh_cleared", err_ghost_o, 0);

        // ---------------- reset mid-stream discards accounting ----------------
        req_valid_i = 1'b1;
        tick();
        tick();
        req_valid_i = 1'b0;
        chk("ms_cnt2", inflight_o, 2);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        pe_valid_i = 1'b1;
        tick();
        pe_valid_i = 1'b0;
        chk("ms_ghost", err_ghost_o, 1);
        chk("ms_cnt0", inflight_o, 0);

        // ---------------- random loopback ----------------
        do_reset();
        sent   = 0;
        pend   = 0;
        m      = 0;
        budget = 0;
        mctrl  = PE_MODE_NTT;
        while ((sent < 100 || pend != 0) && budget < 5000) begin
            budget++;
            req_valid_i = (sent < 100) && ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0)
                req_mode_i = ($urandom_range(1) != 0) ? PE_MODE_INTT : PE_MODE_NTT;
            req_a_i    = coeff_t'($urandom);
            req_b_i    = coeff_t'($urandom);
            req_w_i    = coeff_t'($urandom);
            pe_valid_i = (pend != 0) && ($urandom_range(1) != 0);
            #1;
            acc = req_valid_i && req_ready_o;
            if (acc && (req_mode_i != mctrl))
                chk("rnd_switch_empty", inflight_o, 0);
            tick();
            if (acc) begin
                m++;
                sent++;
                mctrl = req_mode_i;
            end
            if (pe_valid_i) begin
                m--;
                pend--;
            end
            if (valid_o) pend++;
            chk("rnd_inflight", inflight_o, m);
            chk("rnd_ctrl", ctrl_o, mctrl);
            chk("rnd_ghost", err_ghost_o, 0);
        end
        idle_inputs();
        chk("rnd_complete", (sent == 100) && (pend == 0), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
